// File: rtl/sine_pkg.sv
// sine_pkg: constants and types shared by the sine_pwm slice.
// Holds the sample width, the midscale helper and the dead-time FSM state type.
`timescale 1ns/1ps

package sine_pkg;

  // Width of the signed sample stream produced by the sinewave generator.
  localparam int SAMPLE_W = 16;

  // XOR mask that flips the sign bit, turning two's complement into offset binary.
  localparam logic [SAMPLE_W-1:0] SIGN_FLIP = 16'h8000;

  // Widest duty/counter width the block supports.
  localparam int PWM_BITS_MAX = 16;

  // States of the complementary-output dead-time FSM.
  typedef enum logic [1:0] {
    DT_LOW  = 2'd0,  // low side on
    DT_RISE = 2'd1,  // both off, heading high
    DT_HIGH = 2'd2,  // high side on
    DT_FALL = 2'd3   // both off, heading low
  } dt_state_t;

  // Midscale duty (50 %) for a given duty width: 2^(bits-1).
  function automatic logic [PWM_BITS_MAX-1:0] midscale(input int bits);
    return PWM_BITS_MAX'(1) << (bits - 1);
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns the raw PWM compare result into a complementary
// high-side / low-side pair with DEAD_CYCLES of both-off time at every
// transition. Pulses shorter than the dead time are swallowed. Only
// instantiated when SINE_PWM_DEADTIME_EN is defined.
`timescale 1ns/1ps

module pwm_deadtime
  import sine_pkg::*;
#(
  parameter int DEAD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pwm_out,
  output logic pwm_n
);

  // Down-counter reload value: DEAD_CYCLES clocks spent in each dead state.
  localparam logic [3:0] DT_LOAD = 4'(DEAD_CYCLES - 1);

  dt_state_t  state;
  logic [3:0] dcnt;

  // Dead-time FSM; outputs are registered together with the next state so
  // they always match the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= DT_LOW;
      dcnt    <= '0;
      pwm_out <= 1'b0;
      pwm_n   <= 1'b0;
    end else begin
      case (state)
        DT_LOW: begin
          if (raw) begin
            state   <= DT_RISE;
            dcnt    <= DT_LOAD;
            pwm_out <= 1'b0;
            pwm_n   <= 1'b0;
          end else begin
            pwm_out <= 1'b0;
            pwm_n   <= 1'b1;
          end
        end
        DT_RISE: begin
          if (!raw) begin
            // Pulse ended inside the dead band: fall back without ever driving high.
            state   <= DT_LOW;
            pwm_out <= 1'b0;
            pwm_n   <= 1'b1;
          end else if (dcnt == '0) begin
            state   <= DT_HIGH;
            pwm_out <= 1'b1;
            pwm_n   <= 1'b0;
          end else begin
            dcnt    <= dcnt - 4'd1;
            pwm_out <= 1'b0;
            pwm_n   <= 1'b0;
          end
        end
        DT_HIGH: begin
          if (!raw) begin
            state   <= DT_FALL;
            dcnt    <= DT_LOAD;
            pwm_out <= 1'b0;
            pwm_n   <= 1'b0;
          end else begin
            pwm_out <= 1'b1;
            pwm_n   <= 1'b0;
          end
        end
        DT_FALL: begin
          if (raw) begin
            state   <= DT_HIGH;
            pwm_out <= 1'b1;
            pwm_n   <= 1'b0;
          end else if (dcnt == '0) begin
            state   <= DT_LOW;
            pwm_out <= 1'b0;
            pwm_n   <= 1'b1;
          end else begin
            dcnt    <= dcnt - 4'd1;
            pwm_out <= 1'b0;
            pwm_n   <= 1'b0;
          end
        end
        default: begin
          state   <= DT_LOW;
          pwm_out <= 1'b0;
          pwm_n   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sine_pwm.sv
// sine_pwm: converts the signed sinewave sample stream into a single-bit PWM
// output. Each sample becomes an unsigned duty value, is parked in a pending
// register and is only promoted to the active duty at a period boundary, so a
// period never sees a duty change part-way through.
// Optional feature macro: SINE_PWM_DEADTIME_EN adds the complementary pwm_n
// output with dead-time insertion.
`timescale 1ns/1ps

module sine_pwm
  import sine_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sin_val,
  input  logic                       sample_valid,
`ifdef SINE_PWM_DEADTIME_EN
  output logic                       pwm_n,
`endif
  output logic                       pwm_out,
  output logic                       period_start,
  output logic                       sample_drop
);

  localparam logic [PWM_BITS_MAX-1:0] MID_FULL = midscale(PWM_BITS);
  localparam logic [PWM_BITS-1:0]     MID      = MID_FULL[PWM_BITS-1:0];

  logic [SAMPLE_W-1:0] offset_val;
  logic [PWM_BITS-1:0] duty_in;
  logic [PWM_BITS-1:0] duty_pend;
  logic [PWM_BITS-1:0] duty_act;
  logic [PWM_BITS-1:0] cnt;
  logic                pend_full;
  logic                wrap;
  logic                raw;

  // Offset-binary conversion: flipping the sign bit maps -32768..32767 onto
  // 0..65535; the top PWM_BITS bits are the duty.
  assign offset_val = sin_val ^ SIGN_FLIP;
  assign duty_in    = PWM_BITS'(offset_val >> (SAMPLE_W - PWM_BITS));

  assign wrap = (cnt == '1);
  // Strict less-than: duty all-ones still leaves one low clock per period.
  assign raw  = (cnt < duty_act);

  // Period counter, free-running, wraps naturally at 2^PWM_BITS.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt + PWM_BITS'(1);
      period_start <= wrap;
    end
  end

  // Double buffer: strobes land in duty_pend; the wrap cycle promotes it, or
  // takes a same-cycle strobe straight through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_pend   <= MID;
      duty_act    <= MID;
      pend_full   <= 1'b0;
      sample_drop <= 1'b0;
    end else begin
      sample_drop <= 1'b0;
      if (wrap) begin
        pend_full <= 1'b0;
        if (sample_valid) begin
          duty_pend <= duty_in;
          duty_act  <= duty_in;
        end else begin
          duty_act  <= duty_pend;
        end
      end else if (sample_valid) begin
        duty_pend   <= duty_in;
        pend_full   <= 1'b1;
        // Newest sample wins; flag that an unconsumed one was overwritten.
        sample_drop <= pend_full;
      end
    end
  end

`ifdef SINE_PWM_DEADTIME_EN
  pwm_deadtime #(
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_deadtime (
    .clk     (clk),
    .reset   (reset),
    .raw     (raw),
    .pwm_out (pwm_out),
    .pwm_n   (pwm_n)
  );
`else
  // Plain output path: raw compare result registered once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= raw;
    end
  end
`endif

endmodule

// File: tb/tb_sine_pwm.sv
// tb_sine_pwm: directed self-checking bench for sine_pwm with PWM_BITS = 8.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same
// point so they are stable for the next edge.
`timescale 1ns/1ps

module tb_sine_pwm;

  localparam int PWM_BITS = 8;
  localparam int PERIOD   = 256;

  logic               clk          = 1'b0;
  logic               reset        = 1'b1;
  logic signed [15:0] sin_val      = '0;
  logic               sample_valid = 1'b0;
  logic               pwm_out;
  logic               period_start;
  logic               sample_drop;
`ifdef SINE_PWM_DEADTIME_EN
  logic               pwm_n;
`endif

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  sine_pwm #(
    .PWM_BITS    (PWM_BITS),
    .DEAD_CYCLES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sin_val      (sin_val),
    .sample_valid (sample_valid),
`ifdef SINE_PWM_DEADTIME_EN
    .pwm_n        (pwm_n),
`endif
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .sample_drop  (sample_drop)
  );

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until period_start is seen or the budget runs out.
  task automatic wait_ps(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < budget);
  endtask

  // One full period starting at a period_start sample. Strobes fire in the
  // cycle where cnt equals s1 / s2 (-1 = none).
  task automatic run_period(input int s1, input logic [15:0] v1,
                            input int s2, input logic [15:0] v2,
                            output int high, output int drops, output int starts);
    high = 0; drops = 0; starts = 0;
    for (int i = 0; i < PERIOD; i++) begin
      high   += pwm_out ? 1 : 0;
      drops  += sample_drop ? 1 : 0;
      starts += period_start ? 1 : 0;
      sample_valid = (i == s1) || (i == s2);
      sin_val      = (i == s2) ? v2 : v1;
      step();
    end
    sample_valid = 1'b0;
  endtask

`ifdef SINE_PWM_DEADTIME_EN
  task automatic run_dt_period(output int high, output int low_side,
                               output int both_low, output int both_high);
    high = 0; low_side = 0; both_low = 0; both_high = 0;
    for (int i = 0; i < PERIOD; i++) begin
      high      += pwm_out ? 1 : 0;
      low_side  += pwm_n ? 1 : 0;
      both_low  += (!pwm_out && !pwm_n) ? 1 : 0;
      both_high += (pwm_out && pwm_n) ? 1 : 0;
      step();
    end
  endtask
`endif

  int n, high, drops, starts;
`ifdef SINE_PWM_DEADTIME_EN
  int low_side, both_low, both_high;
`endif

  initial begin
    // Reset state.
    repeat (3) step();
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_period_start", int'(period_start), 0);
    check("reset_sample_drop", int'(sample_drop), 0);
`ifdef SINE_PWM_DEADTIME_EN
    check("reset_pwm_n", int'(pwm_n), 0);
`endif
    reset = 1'b0;

    // First period boundary exactly 256 clocks after release.
    wait_ps(300, n);
    check("first_period_start", n, PERIOD);

`ifdef SINE_PWM_DEADTIME_EN
    // Midscale with 4-clock dead time on each edge.
    run_dt_period(high, low_side, both_low, both_high);
    check("dt_high_count", high, 124);
    check("dt_low_side_count", low_side, 124);
    check("dt_both_low_count", both_low, 8);
    check("dt_both_high_count", both_high, 0);
    run_dt_period(high, low_side, both_low, both_high);
    check("dt_high_count_2", high, 124);
    check("dt_both_high_count_2", both_high, 0);
    check("dt_period_start_next", int'(period_start), 1);

    // Reset mid-HIGH forces both outputs low immediately.
    repeat (60) step();
    check("dt_pre_reset_high", int'(pwm_out), 1);
    #10 reset = 1'b1;
    #1;
    check("dt_async_pwm_out", int'(pwm_out), 0);
    check("dt_async_pwm_n", int'(pwm_n), 0);
    check("dt_async_period_start", int'(period_start), 0);
    step();
    reset = 1'b0;
    wait_ps(300, n);
    check("dt_post_reset_period_start", n, PERIOD);
    run_dt_period(high, low_side, both_low, both_high);
    check("dt_post_reset_high", high, 124);
`else
    // No strobes: midscale, 128 high clocks, one period_start per period.
    run_period(-1, 16'h0000, -1, 16'h0000, high, drops, starts);
    check("mid_high", high, 128);
    check("mid_starts", starts, 1);
    run_period(-1, 16'h0000, -1, 16'h0000, high, drops, starts);
    check("mid_high_2", high, 128);
    check("mid_drops", drops, 0);
    check("mid_period_start_next", int'(period_start), 1);

    // 0x8000 mid-period: current period untouched, then constantly low.
    run_period(100, 16'h8000, -1, 16'h0000, high, drops, starts);
    check("min_current_high", high, 128);
    run_period(-1, 16'h0000, -1, 16'h0000, high, drops, starts);
    check("min_next_high", high, 0);

    // 0x7FFF during a duty-0 period, then 0x4000.
    run_period(50, 16'h7FFF, -1, 16'h0000, high, drops, starts);
    check("min_following_high", high, 0);
    run_period(60, 16'h4000, -1, 16'h0000, high, drops, starts);
    check("max_high", high, 255);

    // Two strobes in one period: one drop, the later one (duty 0) wins.
    run_period(10, 16'h0000, 20, 16'h8000, high, drops, starts);
    check("quarter_high", high, 192);
    check("double_strobe_drops", drops, 1);

    // Pending 0x0000 then a wrap-cycle strobe 0x7FFF: bypass wins, no drop.
    run_period(30, 16'h0000, 255, 16'h7FFF, high, drops, starts);
    check("drop_winner_high", high, 0);
    check("wrap_period_drops", drops, 0);
    check("wrap_sample_drop", int'(sample_drop), 0);
    check("wrap_period_start", int'(period_start), 1);
    run_period(-1, 16'h0000, -1, 16'h0000, high, drops, starts);
    check("bypass_high", high, 255);

    // Asynchronous reset mid-period while the output is high.
    repeat (50) step();
    check("pre_reset_high", int'(pwm_out), 1);
    #10 reset = 1'b1;
    #1;
    check("async_pwm_out", int'(pwm_out), 0);
    check("async_period_start", int'(period_start), 0);
    step();
    reset = 1'b0;
    wait_ps(300, n);
    check("post_reset_period_start", n, PERIOD);
    run_period(-1, 16'h0000, -1, 16'h0000, high, drops, starts);
    check("post_reset_mid_high", high, 128);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
